// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with wait states, lane stores and extended loads
// Latches one request, waits WAIT_STATES cycles, accesses word RAM, then strobes o_Ready for one cycle.
module data_mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_Req,
    input  logic                     i_We,
    input  logic [ADDRESS_WIDTH-1:0] i_Addr,
    input  logic [DATA_WIDTH-1:0]    i_WData,
    input  logic [1:0]               i_RAM_sel,
    input  logic                     i_Unsigned,
    output logic                     o_Ready,
    output logic [DATA_WIDTH-1:0]    o_RData,
    output logic                     o_Busy,
    output logic                     o_AddrErr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic            uns_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      sel_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     ram_word;
    logic [31:0]     shifted;
    logic            misaligned;
    logic [31:0]     rdata_d;
    logic [31:0]     wmask;
    logic [31:0]     wrep;
    logic [31:0]     merged_d;
    logic            unused_addr_hi;

    // Address bits above the RAM index alias, so they are intentionally dropped.
    assign unused_addr_hi = ^i_Addr[ADDRESS_WIDTH-1:AW+2];

    assign ram_word = mem_q[addr_q[AW+1:2]];
    assign shifted  = ram_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        rdata_d    = ram_word;
        wmask      = 32'hFFFF_FFFF;
        wrep       = wdata_q;
        case (sel_q)
            2'b01: begin
                misaligned = addr_q[0];
                rdata_d    = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                wmask      = 32'h0000_FFFF << {addr_q[1], 4'b0000};
                wrep       = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                rdata_d    = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                wmask      = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                wrep       = {4{wdata_q[7:0]}};
            end
            default: begin
                misaligned = (addr_q[1:0] != 2'b00);
            end
        endcase
        if (misaligned) begin
            rdata_d = 32'b0;
        end
        merged_d = (ram_word & ~wmask) | (wrep & wmask);
    end

    assign o_Busy = ((state_q == S_IDLE) && i_Req) || (state_q == S_WAIT) || (state_q == S_ACCESS);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            o_Ready   <= 1'b0;
            o_RData   <= '0;
            o_AddrErr <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Req) begin
                        we_q    <= i_We;
                        uns_q   <= i_Unsigned;
                        addr_q  <= i_Addr[AW+1:0];
                        wdata_q <= i_WData;
                        sel_q   <= i_RAM_sel;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_Ready   <= 1'b1;
                    o_RData   <= rdata_d;
                    o_AddrErr <= misaligned;
                    state_q   <= S_RESP;
                end
                default: begin
                    o_Ready   <= 1'b0;
                    o_RData   <= '0;
                    o_AddrErr <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // RAM is never cleared; a reset on the ACCESS edge drops the pending store.
    always_ff @(posedge i_CLK) begin
        if (!i_RST && (state_q == S_ACCESS) && we_q && !misaligned) begin
            mem_q[addr_q[AW+1:2]] <= merged_d;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// dut0 uses WAIT_STATES=2, dut1 uses WAIT_STATES=0; request fields are shared, request valids are separate.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  sel;
    logic        req0, req1;
    logic        rdy0, rdy1, busy0, busy1, err0, err1;
    logic [31:0] rd0, rd1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_STATES(2)) dut0 (
        .i_CLK(clk), .i_RST(rst), .i_Req(req0), .i_We(we), .i_Addr(addr), .i_WData(wdata),
        .i_RAM_sel(sel), .i_Unsigned(uns), .o_Ready(rdy0), .o_RData(rd0), .o_Busy(busy0),
        .o_AddrErr(err0)
    );

    data_mem_responder #(.WAIT_STATES(0)) dut1 (
        .i_CLK(clk), .i_RST(rst), .i_Req(req1), .i_We(we), .i_Addr(addr), .i_WData(wdata),
        .i_RAM_sel(sel), .i_Unsigned(uns), .o_Ready(rdy1), .o_RData(rd1), .o_Busy(busy1),
        .o_AddrErr(err1)
    );

    // Issues one request and reports data, error, ready latency (cycles after T) and busy cycle count.
    task automatic access(input int which, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u, output logic [31:0] rdata,
                          output logic aerr, output int lat, output int busy_n);
        logic r, b;
        lat = -1; busy_n = 0; rdata = '0; aerr = 1'b0;
        @(posedge clk); #1;
        we = w; addr = a; wdata = d; sel = s; uns = u;
        if (which == 0) req0 = 1'b1; else req1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            r = (which == 0) ? rdy0 : rdy1;
            b = (which == 0) ? busy0 : busy1;
            if (b) busy_n++;
            if (r) begin
                lat   = k;
                rdata = (which == 0) ? rd0 : rd1;
                aerr  = (which == 0) ? err0 : err1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        we = 1'b0; uns = 1'b0; addr = '0; wdata = '0; sel = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdy0, err0, busy0, rd0} !== 35'b0) begin
            failures++; $display("FAIL reset_dut0 got=%h exp=0", {rdy0, err0, busy0, rd0});
        end
        checks++;
        if ({rdy1, err1, busy1, rd1} !== 35'b0) begin
            failures++; $display("FAIL reset_dut1 got=%h exp=0", {rdy1, err1, busy1, rd1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] rd; logic e; int lat, bn;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (lat !== 4 || bn !== 4) begin
            failures++; $display("FAIL rt_store_timing lat=%0d busy=%0d exp lat=4 busy=4", lat, bn);
        end
        access(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++; $display("FAIL rt_load_data got=%h err=%b exp=deadbeef err=0", rd, e);
        end
        checks++;
        if (lat !== 4 || bn !== 4) begin
            failures++; $display("FAIL rt_load_timing lat=%0d busy=%0d exp lat=4 busy=4", lat, bn);
        end
    endtask

    task automatic test_byte_extend();
        logic [31:0] rd; logic e; int lat, bn;
        access(0, 1'b1, 32'h20, 32'h80FF7F01, 2'b00, 1'b0, rd, e, lat, bn);
        access(0, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL byte_signed got=%h exp=ffffffff", rd);
        end
        access(0, 1'b0, 32'h22, 32'h0, 2'b10, 1'b1, rd, e, lat, bn);
        checks++;
        if (rd !== 32'h000000FF) begin
            failures++; $display("FAIL byte_unsigned got=%h exp=000000ff", rd);
        end
        access(0, 1'b0, 32'h21, 32'h0, 2'b10, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'h0000007F) begin
            failures++; $display("FAIL byte_pos got=%h exp=0000007f", rd);
        end
        access(0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'hFFFF80FF || e !== 1'b0) begin
            failures++; $display("FAIL half_signed got=%h err=%b exp=ffff80ff err=0", rd, e);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic e; int lat, bn;
        access(0, 1'b1, 32'h22, 32'hFFFF1234, 2'b01, 1'b0, rd, e, lat, bn);
        access(0, 1'b1, 32'h20, 32'hFFFFFFAB, 2'b10, 1'b0, rd, e, lat, bn);
        access(0, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'h12347FAB) begin
            failures++; $display("FAIL partial_store got=%h exp=12347fab", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic e; int lat, bn;
        access(0, 1'b1, 32'h13, 32'h99999999, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 4) begin
            failures++; $display("FAIL mis_word_store err=%b data=%h lat=%0d exp err=1 data=0 lat=4", e, rd, lat);
        end
        access(0, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, rd, e, lat, bn);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL mis_half_load err=%b data=%h exp err=1 data=0", e, rd);
        end
        access(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++; $display("FAIL mis_unchanged got=%h err=%b exp=deadbeef err=0", rd, e);
        end
    endtask

    task automatic test_zero_wait_wrap();
        logic [31:0] rd; logic e; int lat, bn;
        access(1, 1'b1, 32'h400, 32'hCAFEF00D, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (lat !== 2 || bn !== 2) begin
            failures++; $display("FAIL zw_store_timing lat=%0d busy=%0d exp lat=2 busy=2", lat, bn);
        end
        access(1, 1'b0, 32'h000, 32'h0, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'hCAFEF00D || lat !== 2) begin
            failures++; $display("FAIL zw_wrap_load got=%h lat=%0d exp=cafef00d lat=2", rd, lat);
        end
    endtask

    // Request held high: second access accepted in the IDLE gap; address change after acceptance is ignored.
    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat, bn;
        int n_rdy, k1, k2;
        logic [31:0] d1, d2;
        access(0, 1'b1, 32'h40, 32'h01020304, 2'b00, 1'b0, rd, e, lat, bn);
        access(0, 1'b1, 32'h44, 32'hA5A5A5A5, 2'b00, 1'b0, rd, e, lat, bn);
        n_rdy = 0; k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        @(posedge clk); #1;
        we = 1'b0; addr = 32'h40; sel = 2'b00; uns = 1'b0; req0 = 1'b1;
        for (int k = 0; k < 30 && n_rdy < 2; k++) begin
            @(negedge clk);
            if (rdy0) begin
                if (n_rdy == 0) begin k1 = k; d1 = rd0; end
                else begin k2 = k; d2 = rd0; end
                n_rdy++;
            end
            @(posedge clk); #1;
            if (k == 0) addr = 32'h44;
        end
        req0 = 1'b0;
        checks++;
        if (k1 !== 4 || k2 !== 9) begin
            failures++; $display("FAIL b2b_timing k1=%0d k2=%0d exp 4 and 9", k1, k2);
        end
        checks++;
        if (d1 !== 32'h01020304 || d2 !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL b2b_data d1=%h d2=%h exp 01020304 a5a5a5a5", d1, d2);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic e; int lat, bn;
        int pulses;
        access(0, 1'b1, 32'h30, 32'h55AA55AA, 2'b00, 1'b0, rd, e, lat, bn);
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h30; wdata = 32'h11111111; sel = 2'b00; req0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({rdy0, err0, busy0, rd0} !== 35'b0) begin
            failures++; $display("FAIL rst_mid_outputs got=%h exp=0", {rdy0, err0, busy0, rd0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rdy0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++; $display("FAIL rst_mid_no_ready got=%0d exp=0", pulses);
        end
        access(0, 1'b0, 32'h30, 32'h0, 2'b00, 1'b0, rd, e, lat, bn);
        checks++;
        if (rd !== 32'h55AA55AA) begin
            failures++; $display("FAIL rst_mid_old_value got=%h exp=55aa55aa", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_extend();
        test_partial_store();
        test_misalign();
        test_zero_wait_wrap();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that sits on the memory-stage side of the processor's load/store interface. It accepts one word, halfword or byte request at a time from the memory stage, inserts a configurable number of wait states, and performs the write or read on internal word-organised RAM. It returns load data already sign- or zero-extended, and drives a busy signal the hazard unit uses to stall the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDRESS_WIDTH, 32, byte address width.
- DEPTH_WORDS, 256, RAM depth in 32-bit words; must be a power of two and ≥ 2.
- WAIT_STATES, 2, extra wait cycles per access; range 0–15.

Ports:
- i_CLK  in  1  clock; everything samples on the rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_Req  in  1  request valid; the requester holds it (and all request fields) stable until o_Ready.
- i_We  in  1  1 = store, 0 = load.
- i_Addr  in  ADDRESS_WIDTH  byte address.
- i_WData  in  DATA_WIDTH  store data; the data for a byte or half access sits in the low bits.
- i_RAM_sel  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- i_Unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- o_Ready  out  1  one-cycle completion strobe.
- o_RData  out  DATA_WIDTH  extended load data; valid while o_Ready = 1.
- o_Busy  out  1  stall request to the hazard unit.
- o_AddrErr  out  1  misaligned-request flag; valid while o_Ready = 1.

## Operation
- The state machine has four states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If i_Req = 1, latch i_We, i_Addr, i_WData, i_RAM_sel and i_Unsigned.
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, otherwise ACCESS.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is ACCESS. This gives exactly WAIT_STATES cycles in WAIT.
- ACCESS: perform the RAM operation using the latched fields, then go to RESP.
- RESP: o_Ready = 1 for exactly one cycle, then go to IDLE. i_Req is ignored in RESP.
- Alignment check:
  - A half access with addr[0] = 1 is misaligned.
  - A word access with addr[1:0] ≠ 00 is misaligned.
  - For a misaligned request, ACCESS does not modify RAM, o_RData = 0, and o_AddrErr = 1 in RESP.
- Word index is addr[log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so addresses alias and wrap modulo 4·DEPTH_WORDS bytes.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte store writes WData[7:0] into the selected lane only.
  - Half store writes WData[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
  - Lanes that are not written keep their value.
- Loads extract the selected byte or half and extend it to 32 bits per i_Unsigned. Word loads pass through unchanged.
- o_Busy (combinational) = (IDLE & i_Req) | WAIT | ACCESS. It is low in RESP, so the pipeline advances on the same edge it captures o_RData.
- Reset values: state IDLE, counter 0, o_Ready 0, o_RData 0, o_AddrErr 0. RAM contents are not cleared.

## Timing
- A request first seen in IDLE in cycle T produces o_Ready in cycle T + WAIT_STATES + 2.
- With WAIT_STATES = 0: T accept, T+1 ACCESS, T+2 RESP.
- o_Busy is high from cycle T through T + WAIT_STATES + 1, and low in RESP.
- The RAM write commits on the rising edge that ends ACCESS.
- A load issued after a store completes returns the stored data (no read-during-write hazard at the interface).
- If i_Req is still high in the IDLE cycle after RESP, it is accepted as a new request. Back-to-back requests therefore have a one-cycle IDLE gap, giving a throughput of one access per WAIT_STATES + 3 cycles.
- i_RST asserted in any state returns to IDLE on the next edge. A store that has not reached the end of ACCESS is dropped. No o_Ready is produced for the aborted request.
- Changing request inputs after acceptance has no effect; the latched copy is used.

## Test plan
- Aligned word round trip (WAIT_STATES = 2):
  - Stimulus: word store 0xDEADBEEF to 0x10, then word load from 0x10.
  - Required: o_RData = 0xDEADBEEF; o_Ready at T+4 for each access; o_Busy high for 4 cycles.
- Byte sign/zero extension:
  - Stimulus: word store 0x80FF7F01 to 0x20, then byte loads at 0x22 with i_Unsigned = 0 and 1, then byte load at 0x21 with i_Unsigned = 0.
  - Required: 0xFFFFFFFF, 0x000000FF, and 0x0000007F respectively.
- Partial stores:
  - Stimulus: half store 0x1234 to 0x22 and byte store 0xAB to 0x20 over an existing word 0x80FF7F01.
  - Required: a word load from 0x20 returns 0x12347FAB.
- Misalignment:
  - Stimulus: word store to 0x13 and half load from 0x21.
  - Required: each gives o_AddrErr = 1 with o_Ready and o_RData = 0; a subsequent word load from 0x10 returns the prior contents unchanged.
- Zero wait states and wrap (WAIT_STATES = 0, DEPTH_WORDS = 256):
  - Stimulus: word store 0xCAFEF00D to 0x400, then word load from 0x000.
  - Required: load returns 0xCAFEF00D; o_Ready at T+2.
- Reset mid-operation:
  - Stimulus: assert i_RST during WAIT of a store 0x11111111 to 0x30.
  - Required: o_Ready never pulses; all outputs read 0 next cycle; a later load from 0x30 returns the old value.
